// File: rtl/pico_ram_bridge_if.sv
// rtl/pico_ram_bridge_if.sv - PicoRV32 native memory bus between core (master) and slave.
interface pico_ram_bridge_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/pico_ram_bridge.sv
// rtl/pico_ram_bridge.sv - Windowed byte-writable RAM slave with programmable read latency and saturating access counters.
module pico_ram_bridge #(
    parameter logic [31:0] BASE   = 32'h1000_1000,
    parameter int          ADDR_W = 12,
    parameter int          RD_LAT = 1,
    parameter int          CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pico_ram_bridge_if.slave     bus,
    output logic                 hit,
    output logic [CNT_W-1:0]     rd_count,
    output logic [CNT_W-1:0]     wr_count
);

    typedef enum logic [1:0] {IDLE, WRITE_RESP, READ_WAIT, READ_RESP} state_t;

    // Window bounds are compared at 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_W);

    state_t            state;
    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_idx;
    logic [2:0]        lat_cnt;
    logic              accept;
    logic              wr_en;
    logic              ready_q;
    logic [31:0]       rdata_q;

    assign hit      = ({1'b0, bus.mem_addr} >= WIN_LO) && ({1'b0, bus.mem_addr} < WIN_HI);
    assign word_idx = bus.mem_addr[ADDR_W+1:2];
    assign accept   = (state == IDLE) && bus.mem_valid && hit && !reset;
    assign wr_en    = accept && (bus.mem_wstrb != 4'd0);
    // In IDLE the RAM is addressed straight from the bus so data is ready one edge after accept.
    assign rd_idx   = (state == IDLE) ? word_idx : addr_q;

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb[b]) begin
                    ram[word_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
        ram_q <= ram[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            rdata_q  <= 32'd0;
            rd_count <= '0;
            wr_count <= '0;
            lat_cnt  <= 3'd0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.mem_wstrb != 4'd0) begin
                            ready_q <= 1'b1;
                            state   <= WRITE_RESP;
                        end else begin
                            addr_q  <= word_idx;
                            lat_cnt <= 3'(RD_LAT);
                            state   <= READ_WAIT;
                        end
                    end
                end
                WRITE_RESP: begin
                    ready_q <= 1'b0;
                    if (wr_count != '1) wr_count <= wr_count + 1'b1;
                    state   <= IDLE;
                end
                READ_WAIT: begin
                    if (!bus.mem_valid) begin
                        lat_cnt <= 3'd0;
                        state   <= IDLE;
                    end else if (lat_cnt == 3'd1) begin
                        lat_cnt <= 3'd0;
                        rdata_q <= ram_q;
                        ready_q <= 1'b1;
                        state   <= READ_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                READ_RESP: begin
                    ready_q <= 1'b0;
                    rdata_q <= 32'd0;
                    if (rd_count != '1) rd_count <= rd_count + 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_ram_bridge.sv
// tb/tb_pico_ram_bridge.sv - Directed self-checking bench for pico_ram_bridge across several parameter sets.
module tb_pico_ram_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    int          sel = 1;
    int          n_tests = 0;
    int          n_fail = 0;
    int          lat;
    int          rdy;
    logic [31:0] rd;
    bit          leak;
    int          sat_exp [5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    pico_ram_bridge_if if1 ();
    pico_ram_bridge_if if4 ();
    pico_ram_bridge_if if3 ();
    pico_ram_bridge_if ifc ();

    assign if1.mem_valid = valid && (sel == 1);
    assign if4.mem_valid = valid && (sel == 4);
    assign if3.mem_valid = valid && (sel == 3);
    assign ifc.mem_valid = valid && (sel == 5);
    assign if1.mem_addr = addr;  assign if1.mem_wdata = wdata;  assign if1.mem_wstrb = wstrb;
    assign if4.mem_addr = addr;  assign if4.mem_wdata = wdata;  assign if4.mem_wstrb = wstrb;
    assign if3.mem_addr = addr;  assign if3.mem_wdata = wdata;  assign if3.mem_wstrb = wstrb;
    assign ifc.mem_addr = addr;  assign ifc.mem_wdata = wdata;  assign ifc.mem_wstrb = wstrb;

    logic        h1, h4, h3, hc;
    logic [15:0] rc1, wc1, rc4, wc4, rc3, wc3;
    logic [1:0]  rcc, wcc;

    pico_ram_bridge #(.RD_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(if1), .hit(h1), .rd_count(rc1), .wr_count(wc1));
    pico_ram_bridge #(.RD_LAT(4)) u4 (.clk(clk), .reset(reset), .bus(if4), .hit(h4), .rd_count(rc4), .wr_count(wc4));
    pico_ram_bridge #(.RD_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(if3), .hit(h3), .rd_count(rc3), .wr_count(wc3));
    pico_ram_bridge #(.RD_LAT(1), .CNT_W(2)) uc (.clk(clk), .reset(reset), .bus(ifc), .hit(hc), .rd_count(rcc), .wr_count(wcc));

    logic        cur_ready;
    logic        cur_hit;
    logic [31:0] cur_rdata;
    logic [31:0] cur_rc;
    logic [31:0] cur_wc;

    always_comb begin
        cur_ready = if1.mem_ready;
        cur_hit   = h1;
        cur_rdata = if1.mem_rdata;
        cur_rc    = {16'd0, rc1};
        cur_wc    = {16'd0, wc1};
        case (sel)
            4: begin
                cur_ready = if4.mem_ready; cur_hit = h4; cur_rdata = if4.mem_rdata;
                cur_rc = {16'd0, rc4}; cur_wc = {16'd0, wc4};
            end
            3: begin
                cur_ready = if3.mem_ready; cur_hit = h3; cur_rdata = if3.mem_rdata;
                cur_rc = {16'd0, rc3}; cur_wc = {16'd0, wc3};
            end
            5: begin
                cur_ready = ifc.mem_ready; cur_hit = hc; cur_rdata = ifc.mem_rdata;
                cur_rc = {30'd0, rcc}; cur_wc = {30'd0, wcc};
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request held until ready (bounded); lat counts cycles from accept to the ready cycle.
    task automatic xfer(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                        output int l, output logic [31:0] r, output bit lk);
        sel = s; addr = a; wdata = d; wstrb = st; valid = 1'b1;
        l = 0; lk = 1'b0; r = 32'd0;
        do begin
            tick();
            l++;
            if (!cur_ready && cur_rdata !== 32'd0) lk = 1'b1;
        end while (!cur_ready && l < 20);
        r = cur_rdata;
        valid = 1'b0; wstrb = 4'd0;
        tick();
    endtask

    task automatic miss(input logic [31:0] a, output int readys);
        sel = 1; addr = a; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; valid = 1'b1; readys = 0;
        repeat (4) begin
            tick();
            if (cur_ready) readys++;
        end
        valid = 1'b0; wstrb = 4'd0;
    endtask

    initial begin
        sel = 1; addr = 32'h1000_1000; valid = 1'b1; wstrb = 4'd0; reset = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_ready", {31'd0, cur_ready}, 32'd0);
            chk("rst_rdata", cur_rdata, 32'd0);
            chk("rst_rd_count", cur_rc, 32'd0);
            chk("rst_wr_count", cur_wc, 32'd0);
        end
        reset = 1'b0; valid = 1'b0;
        tick();

        xfer(1, 32'h1000_1004, 32'hDEAD_BEEF, 4'hF, lat, rd, leak);
        chk("wr_latency", lat, 1);
        chk("wr_count_1", cur_wc, 1);
        xfer(1, 32'h1000_1004, 32'd0, 4'h0, lat, rd, leak);
        chk("rd_latency", lat, 2);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_count_1", cur_rc, 1);
        chk("ready_after", {31'd0, cur_ready}, 32'd0);
        chk("rdata_after", cur_rdata, 32'd0);

        xfer(1, 32'h1000_1008, 32'h1122_3344, 4'hF, lat, rd, leak);
        xfer(1, 32'h1000_1008, 32'h0000_AA00, 4'b0010, lat, rd, leak);
        xfer(1, 32'h1000_1008, 32'd0, 4'h0, lat, rd, leak);
        chk("byte_strobe", rd, 32'h1122_AA44);
        xfer(1, 32'h1000_1008, 32'h00BB_CC00, 4'b0110, lat, rd, leak);
        xfer(1, 32'h1000_1008, 32'd0, 4'h0, lat, rd, leak);
        chk("mid_strobe", rd, 32'h11BB_CC44);
        chk("wr_count_4", cur_wc, 4);
        chk("rd_count_3", cur_rc, 3);

        xfer(4, 32'h1000_1008, 32'h1122_3344, 4'hF, lat, rd, leak);
        xfer(4, 32'h1000_1008, 32'h0000_AA00, 4'b0010, lat, rd, leak);
        xfer(4, 32'h1000_1008, 32'd0, 4'h0, lat, rd, leak);
        chk("lat4_latency", lat, 5);
        chk("lat4_data", rd, 32'h1122_AA44);
        chk("lat4_rdata_leak", {31'd0, leak}, 32'd0);

        miss(32'h1000_0FFC, rdy);
        chk("below_hit", {31'd0, cur_hit}, 32'd0);
        chk("below_ready", rdy, 0);
        miss(32'h1000_5000, rdy);
        chk("above_hit", {31'd0, cur_hit}, 32'd0);
        chk("above_ready", rdy, 0);
        chk("miss_wr_count", cur_wc, 4);
        chk("miss_rd_count", cur_rc, 3);
        addr = 32'h1000_4FFC;
        tick();
        chk("top_hit", {31'd0, cur_hit}, 32'd1);
        xfer(1, 32'h1000_4FFC, 32'h0BAD_F00D, 4'hF, lat, rd, leak);
        xfer(1, 32'h1000_4FFC, 32'd0, 4'h0, lat, rd, leak);
        chk("top_data", rd, 32'h0BAD_F00D);

        for (int i = 0; i < 5; i++) begin
            xfer(5, 32'h1000_1000, 32'd0, 4'h0, lat, rd, leak);
            chk("sat_rd_count", cur_rc, sat_exp[i]);
        end
        chk("sat_wr_count", cur_wc, 0);

        xfer(3, 32'h1000_100C, 32'h600D_CAFE, 4'hF, lat, rd, leak);
        sel = 3; addr = 32'h1000_100C; wstrb = 4'h0; valid = 1'b1; rdy = 0;
        tick();
        if (cur_ready) rdy++;
        tick();
        if (cur_ready) rdy++;
        valid = 1'b0;
        repeat (6) begin
            tick();
            if (cur_ready) rdy++;
        end
        chk("abort_ready", rdy, 0);
        chk("abort_rd_count", cur_rc, 0);
        xfer(3, 32'h1000_100C, 32'd0, 4'h0, lat, rd, leak);
        chk("post_abort_latency", lat, 4);
        chk("post_abort_data", rd, 32'h600D_CAFE);
        chk("post_abort_rd_count", cur_rc, 1);

        xfer(1, 32'h1000_1000, 32'hCAFE_F00D, 4'hF, lat, rd, leak);
        sel = 1; addr = 32'h1000_1000; wdata = 32'h1234_5678; wstrb = 4'hF; valid = 1'b1; reset = 1'b1;
        rdy = 0;
        repeat (3) begin
            tick();
            if (cur_ready) rdy++;
        end
        reset = 1'b0; valid = 1'b0; wstrb = 4'h0;
        tick();
        chk("rst2_ready", rdy, 0);
        chk("rst2_wr_count", cur_wc, 0);
        xfer(1, 32'h1000_1000, 32'd0, 4'h0, lat, rd, leak);
        chk("rst2_ram_kept", rd, 32'hCAFE_F00D);
        chk("rst2_rd_count", cur_rc, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
